io_ports: RTL

IO_PORTS -- requirements
Module: io_ports

---
 rtl/io_ports.sv | 122 ++++++++++++
 1 files changed

// File: rtl/io_ports.sv
// Memory-mapped I/O port block: per-channel OUT/IN/MASK/STAT registers in a 256-byte window,
// with rising-edge capture into sticky STAT bits and a registered level interrupt.
module io_ports #(
    parameter logic [31:0] BASE    = 32'h1000_0000,
    parameter int unsigned NPORTS  = 1,
    parameter bit          SYNC_IN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            rd_addr,
    input  logic                   rd_req,
    output logic [31:0]            rd_data,
    output logic                   rd_ack,
    input  logic [31:0]            wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_be,
    input  logic                   wr_req,
    input  logic [32*NPORTS-1:0]   inport,
    output logic [32*NPORTS-1:0]   outport,
    output logic                   irq
);

    typedef logic [NPORTS-1:0][31:0] chan_t;

    chan_t       out_q, out_d;
    chan_t       mask_q, mask_d;
    chan_t       stat_q, stat_d;
    chan_t       in_s, in_prev_q, rise;
    logic [31:0] rd_val, rd_data_q, rd_data_d, be_mask;
    logic        rd_hit, wr_hit, rd_ack_q, irq_q, irq_d;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{rd_addr[1:0], wr_addr[1:0]};

    generate
        if (SYNC_IN) begin : g_sync2
            chan_t s1_q, s2_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= inport;
                    s2_q <= s1_q;
                end
            end
            assign in_s = s2_q;
        end else begin : g_sync1
            chan_t s1_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) s1_q <= '0;
                else       s1_q <= inport;
            end
            assign in_s = s1_q;
        end
    endgenerate

    assign rise    = in_s & ~in_prev_q;
    assign rd_hit  = rd_req && (rd_addr[31:8] == BASE[31:8]);
    assign wr_hit  = wr_req && (wr_addr[31:8] == BASE[31:8]);
    assign be_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};

    // Channels at or above NPORTS never match the loop below, so they read as 0.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (rd_addr[7:4] == 4'(i)) begin
                case (rd_addr[3:2])
                    2'd0:    rd_val = out_q[i];
                    2'd1:    rd_val = in_s[i];
                    2'd2:    rd_val = mask_q[i];
                    default: rd_val = stat_q[i];
                endcase
            end
        end
        rd_data_d = rd_hit ? rd_val : '0;
    end

    // W1C is applied before OR-ing in new edges so a same-cycle edge wins.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        stat_d = stat_q;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (wr_hit && wr_addr[7:4] == 4'(i) && wr_addr[3:2] == 2'd0)
                out_d[i] = (out_q[i] & ~be_mask) | (wr_data & be_mask);
            if (wr_hit && wr_addr[7:4] == 4'(i) && wr_addr[3:2] == 2'd2)
                mask_d[i] = (mask_q[i] & ~be_mask) | (wr_data & be_mask);
            if (wr_hit && wr_addr[7:4] == 4'(i) && wr_addr[3:2] == 2'd3)
                stat_d[i] = (stat_q[i] & ~(wr_data & be_mask)) | rise[i];
            else
                stat_d[i] = stat_q[i] | rise[i];
        end
        irq_d = |(stat_q & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            mask_q    <= '0;
            stat_q    <= '0;
            in_prev_q <= '0;
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            mask_q    <= mask_d;
            stat_q    <= stat_d;
            in_prev_q <= in_s;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_hit;
            irq_q     <= irq_d;
        end
    end

    assign outport = out_q;
    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
    assign irq     = irq_q;

endmodule
